// File: rtl/flu_distributor_inum_gen_if.sv
// INUM handshake between the mask generator and the FLU distributor.
// The master presents a mask; the slave pulses INUM_NEXT to consume it.
interface flu_distributor_inum_gen_if #(
  parameter int OUTPUT_PORTS = 4
);
  logic [OUTPUT_PORTS-1:0] INUM_MASK;
  logic                    INUM_READY;
  logic                    INUM_NEXT;

  modport master (
    output INUM_MASK,
    output INUM_READY,
    input  INUM_NEXT
  );

  modport slave (
    input  INUM_MASK,
    input  INUM_READY,
    output INUM_NEXT
  );
endinterface

// File: rtl/flu_distributor_inum_gen.sv
// Per-frame output-port mask generator for the FLU distributor
// (round-robin / fixed / broadcast) with saturating per-port counters.
module flu_distributor_inum_gen #(
  parameter int OUTPUT_PORTS = 4,
  parameter int SEL_WIDTH    = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [1:0]              MODE,
  input  logic [SEL_WIDTH-1:0]    FIXED_PORT,
  input  logic [OUTPUT_PORTS-1:0] PORT_EN,
  flu_distributor_inum_gen_if.master inum,
  input  logic [SEL_WIDTH-1:0]    STAT_SEL,
  input  logic                    STAT_CLR,
  output logic [CNT_WIDTH-1:0]    STAT_CNT
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_VALID = 1'b1;

  localparam logic [1:0] M_FIXED = 2'b01;
  localparam logic [1:0] M_BCAST = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [SEL_WIDTH-1:0] PTR_INIT =
    SEL_WIDTH'(OUTPUT_PORTS - 1);

  logic [0:0]              state_q, state_d;
  logic [OUTPUT_PORTS-1:0] mask_q, mask_d;
  logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]    cnt_q [OUTPUT_PORTS];
  logic [CNT_WIDTH-1:0]    cnt_d [OUTPUT_PORTS];
  logic [CNT_WIDTH-1:0]    stat_q, stat_d;

  logic [OUTPUT_PORTS-1:0] rr_mask;
  logic [SEL_WIDTH-1:0]    rr_idx;
  logic [OUTPUT_PORTS-1:0] fix_mask;
  logic [OUTPUT_PORTS-1:0] cand;
  logic                    is_rr;
  logic                    consume;

  // Distance after the pointer ranks ports; the pointer itself ranks last.
  always_comb begin : rr_search
    int best;
    int d;
    best    = OUTPUT_PORTS;
    d       = 0;
    rr_mask = '0;
    rr_idx  = ptr_q;
    for (int i = 0; i < OUTPUT_PORTS; i++) begin
      d = i - int'(ptr_q) - 1;
      if (d < 0) d = d + OUTPUT_PORTS;
      if (PORT_EN[i] && d < best) begin
        best       = d;
        rr_mask    = '0;
        rr_mask[i] = 1'b1;
        rr_idx     = SEL_WIDTH'(i);
      end
    end
  end

  always_comb begin
    fix_mask = '0;
    for (int i = 0; i < OUTPUT_PORTS; i++) begin
      if (PORT_EN[i] && FIXED_PORT == SEL_WIDTH'(i))
        fix_mask[i] = 1'b1;
    end
  end

  always_comb begin
    is_rr = 1'b0;
    unique case (1'b1)
      (MODE == M_FIXED): cand = fix_mask;
      (MODE == M_BCAST): cand = PORT_EN;
      default: begin
        cand  = rr_mask;
        is_rr = 1'b1;
      end
    endcase
  end

  assign consume = (state_q == S_VALID) && inum.INUM_NEXT;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    if (state_q == S_EMPTY || consume) begin
      if (cand != '0) begin
        mask_d  = cand;
        state_d = S_VALID;
        if (is_rr) ptr_d = rr_idx;
      end else begin
        mask_d  = '0;
        state_d = S_EMPTY;
      end
    end
  end

  // A clear of the selected counter overrides a same-cycle increment.
  always_comb begin
    cnt_d  = cnt_q;
    stat_d = '0;
    for (int i = 0; i < OUTPUT_PORTS; i++) begin
      if (STAT_SEL == SEL_WIDTH'(i)) begin
        stat_d = cnt_q[i];
      end
      if (STAT_CLR && STAT_SEL == SEL_WIDTH'(i)) begin
        cnt_d[i] = '0;
      end else if (consume && mask_q[i] && cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_EMPTY;
      mask_q  <= '0;
      ptr_q   <= PTR_INIT;
      cnt_q   <= '{default: '0};
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
    end
  end

  assign inum.INUM_MASK  = mask_q;
  assign inum.INUM_READY = (state_q == S_VALID);
  assign STAT_CNT        = stat_q;

endmodule

// File: tb/tb_flu_distributor_inum_gen.sv
// Directed bench for flu_distributor_inum_gen with 4-bit counters
// so that saturation is reachable in a short run.
module tb_flu_distributor_inum_gen;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [1:0] fixed_port;
  logic [3:0] port_en;
  logic [1:0] stat_sel;
  logic       stat_clr;
  logic [3:0] stat_cnt;

  int checks;
  int errors;

  flu_distributor_inum_gen_if #(.OUTPUT_PORTS(4)) inum_if ();

  flu_distributor_inum_gen #(
    .OUTPUT_PORTS(4),
    .SEL_WIDTH   (2),
    .CNT_WIDTH   (4)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .MODE      (mode),
    .FIXED_PORT(fixed_port),
    .PORT_EN   (port_en),
    .inum      (inum_if),
    .STAT_SEL  (stat_sel),
    .STAT_CLR  (stat_clr),
    .STAT_CNT  (stat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic rdy,
                         input logic [3:0] msk);
    chk({tag, "_rdy"}, 32'(inum_if.INUM_READY), 32'(rdy));
    chk({tag, "_msk"}, 32'(inum_if.INUM_MASK), 32'(msk));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cnt(input string tag,
                          input logic [1:0] sel,
                          input logic [3:0] exp);
    stat_sel = sel;
    tick();
    chk(tag, 32'(stat_cnt), 32'(exp));
  endtask

  task automatic clear_all();
    inum_if.INUM_NEXT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stat_sel = 2'(i);
      stat_clr = 1'b1;
      tick();
    end
    stat_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    mode              = 2'b00;
    fixed_port        = 2'd0;
    port_en           = 4'b1111;
    stat_sel          = 2'd0;
    stat_clr          = 1'b0;
    inum_if.INUM_NEXT = 1'b0;

    #12;
    chk_out("reset", 1'b0, 4'b0000);
    chk("reset_stat", 32'(stat_cnt), 32'h0);

    // round-robin over all ports, back-to-back consumes
    rst_n = 1'b1;
    tick();
    chk_out("rr_first", 1'b1, 4'b0001);
    inum_if.INUM_NEXT = 1'b1;
    tick(); chk_out("rr_p1", 1'b1, 4'b0010);
    tick(); chk_out("rr_p2", 1'b1, 4'b0100);
    tick(); chk_out("rr_p3", 1'b1, 4'b1000);
    tick(); chk_out("rr_wrap", 1'b1, 4'b0001);
    inum_if.INUM_NEXT = 1'b0;
    read_cnt("rr_cnt3", 2'd3, 4'd1);

    // presented mask frozen against config changes
    port_en = 4'b0110;
    mode    = 2'b10;
    tick(); chk_out("frz_bc", 1'b1, 4'b0001);
    mode       = 2'b01;
    fixed_port = 2'd2;
    tick(); chk_out("frz_fix", 1'b1, 4'b0001);

    // round-robin skipping disabled ports
    mode    = 2'b00;
    port_en = 4'b1010;
    inum_if.INUM_NEXT = 1'b1;
    tick();
    inum_if.INUM_NEXT = 1'b0;
    chk_out("skip_0", 1'b1, 4'b0010);
    clear_all();
    inum_if.INUM_NEXT = 1'b1;
    tick(); chk_out("skip_1", 1'b1, 4'b1000);
    tick(); chk_out("skip_2", 1'b1, 4'b0010);
    tick(); chk_out("skip_3", 1'b1, 4'b1000);
    inum_if.INUM_NEXT = 1'b0;
    read_cnt("skip_c1", 2'd1, 4'd2);
    read_cnt("skip_c0", 2'd0, 4'd0);
    read_cnt("skip_c3", 2'd3, 4'd1);

    // fixed port, drop to empty, ignored pulse, re-enable
    mode       = 2'b01;
    fixed_port = 2'd2;
    port_en    = 4'b0100;
    inum_if.INUM_NEXT = 1'b1;
    tick();
    inum_if.INUM_NEXT = 1'b0;
    chk_out("fix_load", 1'b1, 4'b0100);
    port_en = 4'b0000;
    inum_if.INUM_NEXT = 1'b1;
    tick();
    inum_if.INUM_NEXT = 1'b0;
    chk_out("fix_empty", 1'b0, 4'b0000);
    inum_if.INUM_NEXT = 1'b1;
    tick();
    inum_if.INUM_NEXT = 1'b0;
    read_cnt("ign_c2", 2'd2, 4'd1);
    read_cnt("ign_c3", 2'd3, 4'd2);
    port_en = 4'b0100;
    tick();
    chk_out("fix_reen", 1'b1, 4'b0100);

    // broadcast
    mode    = 2'b10;
    port_en = 4'b1011;
    inum_if.INUM_NEXT = 1'b1;
    tick();
    inum_if.INUM_NEXT = 1'b0;
    chk_out("bc_load", 1'b1, 4'b1011);
    clear_all();
    inum_if.INUM_NEXT = 1'b1;
    tick(); chk_out("bc_1", 1'b1, 4'b1011);
    tick(); chk_out("bc_2", 1'b1, 4'b1011);
    tick(); chk_out("bc_3", 1'b1, 4'b1011);
    inum_if.INUM_NEXT = 1'b0;
    read_cnt("bc_c0", 2'd0, 4'd3);
    read_cnt("bc_c1", 2'd1, 4'd3);
    read_cnt("bc_c2", 2'd2, 4'd0);
    read_cnt("bc_c3", 2'd3, 4'd3);

    // saturation on a single-port round-robin
    mode    = 2'b00;
    port_en = 4'b0001;
    inum_if.INUM_NEXT = 1'b1;
    tick();
    inum_if.INUM_NEXT = 1'b0;
    chk_out("sat_load", 1'b1, 4'b0001);
    stat_sel = 2'd0;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    inum_if.INUM_NEXT = 1'b1;
    repeat (17) tick();
    inum_if.INUM_NEXT = 1'b0;
    chk_out("sat_self", 1'b1, 4'b0001);
    read_cnt("sat_c0", 2'd0, 4'd15);

    // clear beats a same-cycle increment
    inum_if.INUM_NEXT = 1'b1;
    stat_clr = 1'b1;
    tick();
    inum_if.INUM_NEXT = 1'b0;
    stat_clr = 1'b0;
    read_cnt("clr_win", 2'd0, 4'd0);
    inum_if.INUM_NEXT = 1'b1;
    tick();
    inum_if.INUM_NEXT = 1'b0;
    read_cnt("post_clr", 2'd0, 4'd1);

    // asynchronous reset mid-stream
    inum_if.INUM_NEXT = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 4'b0000);
    chk("arst_stat", 32'(stat_cnt), 32'h0);
    inum_if.INUM_NEXT = 1'b0;
    port_en = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("arst_first", 1'b1, 4'b0001);
    read_cnt("arst_c0", 2'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
